// File: rtl/hub75_fetchshift_if.sv
// Request and framebuffer-read bundle between the sequencer,
// the framebuffer and the HUB75 fetch/shift block.
interface hub75_fetchshift_if;
    logic        start;
    logic [5:0]  row_sel;
    logic [2:0]  bit_sel;
    logic        busy;
    logic        fb_rd_en;
    logic [11:0] fb_addr;
    logic [23:0] fb_rdata;

    modport master (
        output start,
        output row_sel,
        output bit_sel,
        output fb_rdata,
        input  busy,
        input  fb_rd_en,
        input  fb_addr
    );

    modport slave (
        input  start,
        input  row_sel,
        input  bit_sel,
        input  fb_rdata,
        output busy,
        output fb_rd_en,
        output fb_addr
    );
endinterface

// File: rtl/hub75_fetchshift.sv
// Fetches one row pair for one bitplane from the framebuffer
// and shifts it into the HUB75 column drivers.
module hub75_fetchshift #(
    parameter int COLS = 64
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    hub75_fetchshift_if.slave  bus,
    output logic               r0,
    output logic               g0,
    output logic               b0,
    output logic               r1,
    output logic               g1,
    output logic               b1,
    output logic               panel_clk
);

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_TOP,
        ADDR_BOT,
        LOAD,
        CLK_HI,
        DONE
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [4:0]  row_l;
    logic [2:0]  bit_l;
    logic [5:0]  col;
    logic [2:0]  top_hold;
    logic [2:0]  k;
    logic        rd_en;
    logic [11:0] addr;
    logic        unused_row_msb;

    // Bitplane 0 is the MSB; the rest step up from bit 0.
    assign k = bit_l + 3'd7;
    assign unused_row_msb = bus.row_sel[5];

    function automatic logic [2:0] pick(
        input logic [23:0] px,
        input logic [2:0]  sel
    );
        logic [7:0] rc;
        logic [7:0] gc;
        logic [7:0] bc;
        rc = px[23:16];
        gc = px[15:8];
        bc = px[7:0];
        return {rc[sel], gc[sel], bc[sel]};
    endfunction

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and framebuffer read strobe/address.
    always_comb begin
        state_n = state;
        rd_en   = 1'b0;
        addr    = 12'h000;
        unique case (state)
            IDLE: begin
                if (bus.start) state_n = ADDR_TOP;
            end
            ADDR_TOP: begin
                rd_en   = 1'b1;
                addr    = {1'b0, row_l, col};
                state_n = ADDR_BOT;
            end
            ADDR_BOT: begin
                rd_en   = 1'b1;
                addr    = {1'b1, row_l, col};
                state_n = LOAD;
            end
            LOAD: begin
                state_n = CLK_HI;
            end
            CLK_HI: begin
                state_n = (col == LAST_COL) ? DONE : ADDR_TOP;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.fb_rd_en = rd_en;
    assign bus.fb_addr  = addr;

    // Request latch, column counter, pixel capture and panel pins.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            row_l     <= 5'd0;
            bit_l     <= 3'd0;
            col       <= 6'd0;
            top_hold  <= 3'd0;
            r0        <= 1'b0;
            g0        <= 1'b0;
            b0        <= 1'b0;
            r1        <= 1'b0;
            g1        <= 1'b0;
            b1        <= 1'b0;
            panel_clk <= 1'b0;
        end else begin
            panel_clk <= (state == CLK_HI);
            if (state == IDLE && bus.start) begin
                row_l <= bus.row_sel[4:0];
                bit_l <= bus.bit_sel;
                col   <= 6'd0;
            end
            if (state == ADDR_BOT) begin
                top_hold <= pick(bus.fb_rdata, k);
            end
            if (state == LOAD) begin
                {r0, g0, b0} <= top_hold;
                {r1, g1, b1} <= pick(bus.fb_rdata, k);
            end
            if (state == CLK_HI && col != LAST_COL) begin
                col <= col + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_hub75_fetchshift.sv
// Scoreboard bench for hub75_fetchshift: expected column data is
// queued at start and popped on every panel_clk rising edge.
module tb_hub75_fetchshift;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic r0, g0, b0, r1, g1, b1;
    logic panel_clk;

    hub75_fetchshift_if bus ();

    hub75_fetchshift #(.COLS(64)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus),
        .r0        (r0),
        .g0        (g0),
        .b0        (b0),
        .r1        (r1),
        .g1        (g1),
        .b1        (b1),
        .panel_clk (panel_clk)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    int fb_mode = 0;
    int busy_cnt = 0;
    int pulse_cnt = 0;
    logic pclk_prev = 1'b0;
    logic [5:0] sbq[$];

    function automatic logic [23:0] pix(input logic [11:0] a, input int mode);
        if (mode == 0) return {a[11:6], a[5:0], a[11:6], a[5:0]};
        return (a == 12'h003) ? 24'h800000 : 24'h000000;
    endfunction

    function automatic logic [5:0] expect_col(input int row, input int bsel, input int c);
        logic [11:0] ta;
        logic [11:0] ba;
        logic [23:0] tp;
        logic [23:0] bp;
        int kk;
        ta = {1'b0, 5'(row), 6'(c)};
        ba = {1'b1, 5'(row), 6'(c)};
        kk = (bsel + 7) % 8;
        tp = pix(ta, fb_mode);
        bp = pix(ba, fb_mode);
        return {tp[16+kk], tp[8+kk], tp[kk], bp[16+kk], bp[8+kk], bp[kk]};
    endfunction

    // Framebuffer model with one cycle of read latency.
    always @(posedge sys_clk) begin
        bus.fb_rdata <= bus.fb_rd_en ? pix(bus.fb_addr, fb_mode) : 24'h0;
    end

    // Busy/pulse counters and scoreboard pop on each panel_clk rise.
    always @(negedge sys_clk) begin
        logic [5:0] exp_v;
        if (bus.busy === 1'b1) busy_cnt++;
        if (panel_clk === 1'b1 && pclk_prev === 1'b0) begin
            pulse_cnt++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: rgb=%b with empty scoreboard at %0t",
                         {r0, g0, b0, r1, g1, b1}, $time);
            end else begin
                exp_v = sbq.pop_front();
                if ({r0, g0, b0, r1, g1, b1} !== exp_v) begin
                    errors++;
                    $display("FAIL rgb_column: got %b expected %b at %0t",
                             {r0, g0, b0, r1, g1, b1}, exp_v, $time);
                end
            end
        end
        pclk_prev = panel_clk;
    end

    task automatic kick(input int row, input int bsel);
        @(negedge sys_clk);
        bus.row_sel = 6'(row);
        bus.bit_sel = 3'(bsel);
        bus.start = 1'b1;
        for (int c = 0; c < 64; c++) sbq.push_back(expect_col(row % 32, bsel, c));
        @(negedge sys_clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 600) begin
            @(negedge sys_clk);
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles", bus.busy, n);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        bus.start = 1'b0;
        bus.row_sel = 6'd0;
        bus.bit_sel = 3'd0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({bus.busy, bus.fb_rd_en, bus.fb_addr, r0, g0, b0, r1, g1, b1, panel_clk} !== 20'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rd=%b addr=%h rgb=%b pclk=%b expected all 0",
                     bus.busy, bus.fb_rd_en, bus.fb_addr, {r0, g0, b0, r1, g1, b1}, panel_clk);
        end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_main_shift();
        fb_mode = 0;
        @(negedge sys_clk);
        busy_cnt = 0;
        pulse_cnt = 0;
        kick(5, 1);
        checks++;
        if (bus.busy !== 1'b1 || bus.fb_rd_en !== 1'b1 || bus.fb_addr !== 12'h140) begin
            errors++;
            $display("FAIL cycle1_top: busy=%b rd=%b addr=%h expected 1 1 140",
                     bus.busy, bus.fb_rd_en, bus.fb_addr);
        end
        @(negedge sys_clk);
        checks++;
        if (bus.fb_rd_en !== 1'b1 || bus.fb_addr !== 12'h940) begin
            errors++;
            $display("FAIL cycle2_bot: rd=%b addr=%h expected 1 940", bus.fb_rd_en, bus.fb_addr);
        end
        wait_idle();
        checks++;
        if (busy_cnt != 257 || pulse_cnt != 64 || sbq.size() != 0) begin
            errors++;
            $display("FAIL main_counts: busy=%0d pulses=%0d left=%0d expected 257 64 0",
                     busy_cnt, pulse_cnt, sbq.size());
        end
    endtask

    task automatic test_bitplane_msb();
        fb_mode = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge sys_clk);
            pulse_cnt = 0;
            kick(0, (i == 0) ? 0 : 7);
            wait_idle();
            checks++;
            if (pulse_cnt != 64 || sbq.size() != 0) begin
                errors++;
                $display("FAIL msb_plane%0d: pulses=%0d left=%0d expected 64 0",
                         i, pulse_cnt, sbq.size());
            end
        end
        fb_mode = 0;
    endtask

    task automatic test_row_map();
        logic [11:0] tops[2];
        logic [11:0] bots[2];
        int rows[2];
        rows[0] = 31; tops[0] = 12'h7C0; bots[0] = 12'hFC0;
        rows[1] = 33; tops[1] = 12'h040; bots[1] = 12'h840;
        for (int i = 0; i < 2; i++) begin
            kick(rows[i], 2);
            checks++;
            if (bus.fb_addr !== tops[i]) begin
                errors++;
                $display("FAIL row_map_top%0d: addr=%h expected %h", rows[i], bus.fb_addr, tops[i]);
            end
            @(negedge sys_clk);
            checks++;
            if (bus.fb_addr !== bots[i]) begin
                errors++;
                $display("FAIL row_map_bot%0d: addr=%h expected %h", rows[i], bus.fb_addr, bots[i]);
            end
            wait_idle();
        end
    endtask

    task automatic test_start_ignored();
        pulse_cnt = 0;
        kick(5, 3);
        repeat (49) @(negedge sys_clk);
        bus.row_sel = 6'd9;
        bus.bit_sel = 3'd6;
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (bus.fb_rd_en !== 1'b1 || bus.fb_addr !== 12'h14D) begin
            errors++;
            $display("FAIL start_ignored: rd=%b addr=%h expected 1 14d", bus.fb_rd_en, bus.fb_addr);
        end
        wait_idle();
        checks++;
        if (pulse_cnt != 64 || sbq.size() != 0) begin
            errors++;
            $display("FAIL start_ignored_counts: pulses=%0d left=%0d expected 64 0",
                     pulse_cnt, sbq.size());
        end
    endtask

    task automatic test_back_to_back();
        int n_hi;
        int n_lo;
        n_hi = 0;
        n_lo = 0;
        @(negedge sys_clk);
        pulse_cnt = 0;
        bus.row_sel = 6'd7;
        bus.bit_sel = 3'd4;
        bus.start = 1'b1;
        for (int t = 0; t < 2; t++)
            for (int c = 0; c < 64; c++) sbq.push_back(expect_col(7, 4, c));
        @(negedge sys_clk);
        while (bus.busy === 1'b1 && n_hi < 400) begin
            n_hi++;
            @(negedge sys_clk);
        end
        while (bus.busy !== 1'b1 && n_lo < 10) begin
            n_lo++;
            @(negedge sys_clk);
        end
        bus.start = 1'b0;
        checks++;
        if (n_hi != 257 || n_lo != 1) begin
            errors++;
            $display("FAIL back_to_back_gap: high=%0d low=%0d expected 257 1", n_hi, n_lo);
        end
        wait_idle();
        checks++;
        if (pulse_cnt != 128 || sbq.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_counts: pulses=%0d left=%0d expected 128 0",
                     pulse_cnt, sbq.size());
        end
    endtask

    task automatic test_reset_mid();
        int p;
        bit rd_seen;
        pulse_cnt = 0;
        kick(5, 1);
        repeat (99) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({bus.busy, bus.fb_rd_en, bus.fb_addr, r0, g0, b0, r1, g1, b1, panel_clk} !== 20'h0) begin
            errors++;
            $display("FAIL mid_reset_state: busy=%b rd=%b addr=%h rgb=%b pclk=%b expected all 0",
                     bus.busy, bus.fb_rd_en, bus.fb_addr, {r0, g0, b0, r1, g1, b1}, panel_clk);
        end
        checks++;
        if (pulse_cnt != 24) begin
            errors++;
            $display("FAIL mid_reset_pulses: pulses=%0d expected 24", pulse_cnt);
        end
        sys_rst_n = 1'b1;
        sbq.delete();
        p = pulse_cnt;
        rd_seen = 1'b0;
        repeat (20) begin
            @(negedge sys_clk);
            if (bus.fb_rd_en !== 1'b0) rd_seen = 1'b1;
        end
        checks++;
        if (rd_seen || pulse_cnt != p || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet: reads=%0b pulses=%0d busy=%b expected 0 %0d 0",
                     rd_seen, pulse_cnt, bus.busy, p);
        end
        kick(5, 1);
        checks++;
        if (bus.fb_addr !== 12'h140) begin
            errors++;
            $display("FAIL restart_col0: addr=%h expected 140", bus.fb_addr);
        end
        wait_idle();
        checks++;
        if (pulse_cnt != p + 64 || sbq.size() != 0) begin
            errors++;
            $display("FAIL restart_counts: pulses=%0d left=%0d expected %0d 0",
                     pulse_cnt, sbq.size(), p + 64);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_main_shift();
        test_bitplane_msb();
        test_row_map();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
